fade_gen_multi: RTL and testbench

Parametrised multi-channel waveform generator: a shared position counter steps through a PERIOD-long cycle at a programmable rate. Each of CHANNELS outputs reads that position at a fixed phase offset. Each channel produces a WIDTH-bit level using a selectable shape (trapezoid, triangle, sawtooth, constant), plus an on-chip PWM drive bit. It sits between the top-level rate and mode controls and the LED pins, replacing per-channel single-shape ramps and the separate PWM blocks.

---
 rtl/fade_gen_multi.sv | 148 ++++++++++++++
 tb/tb_fade_gen_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fade_gen_multi.sv
// fade_gen_multi
//   Multi-channel waveform generator. A shared position counter walks through
//   a PERIOD-long cycle at a rate set by step_delay; every channel reads that
//   position at its own fixed phase offset and turns it into a WIDTH-bit level
//   using the shape chosen by mode. The level also drives a per-channel PWM
//   bit, so the outputs can go straight to LED pins.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous, active-low reset
//   en          advance enable; low freezes divider, position and shape
//   step_delay  position advances every step_delay+1 enabled cycles
//   mode        00 trapezoid, 01 triangle, 10 sawtooth, 11 constant MAXV
//   level_out   channel i level at bits [i*WIDTH +: WIDTH]
//   pwm_out     per-channel PWM drive, duty = level / 2^WIDTH
//   wrap        one-cycle pulse starting at the edge that loads position 0
module fade_gen_multi #(
  parameter int WIDTH       = 10,
  parameter int CHANNELS    = 3,
  parameter int PERIOD      = 360,
  parameter int OFFSET_STEP = 120,
  parameter int DELAY_W     = 22
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [DELAY_W-1:0]        step_delay,
  input  logic [1:0]                mode,
  output logic [CHANNELS*WIDTH-1:0] level_out,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      wrap
);

  localparam int          POS_W = $clog2(PERIOD);
  localparam int unsigned PER   = PERIOD;
  localparam int unsigned OFS   = OFFSET_STEP;
  localparam int unsigned SEG   = PERIOD / 6;
  localparam int unsigned HALF  = PERIOD / 2;
  localparam int unsigned MAXV  = (32'd1 << WIDTH) - 32'd1;

  generate
    if ((PERIOD % 6) != 0 || PERIOD < 12 || (CHANNELS - 1) * OFFSET_STEP >= PERIOD) begin : g_cfg_err
      $error("fade_gen_multi: PERIOD must be a multiple of 6, >= 12, and exceed (CHANNELS-1)*OFFSET_STEP");
    end
  endgenerate

  // n*MAXV/d with the product kept at full precision, so n == d lands exactly on MAXV.
  function automatic int unsigned ramp(input int unsigned n, input int unsigned d);
    longint unsigned prod;
    prod = 64'(n) * 64'(MAXV);
    return 32'(prod / 64'(d));
  endfunction

  // Position seen by one channel; a single subtract suffices because the
  // largest offset is below PERIOD.
  function automatic int unsigned chan_phase(input logic [POS_W-1:0] p, input int unsigned ch);
    int unsigned s;
    s = 32'(p) + ch * OFS;
    if (s >= PER) s = s - PER;
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] shape_level(input int unsigned p, input logic [1:0] m);
    int unsigned v;
    v = 0;
    case (m)
      2'b00: begin
        if (p < SEG)            v = ramp(p, SEG - 1);
        else if (p < 3 * SEG)   v = MAXV;
        else if (p < 4 * SEG)   v = ramp(4 * SEG - 1 - p, SEG - 1);
        else                    v = 0;
      end
      2'b01: begin
        if (p < HALF) v = ramp(p, HALF - 1);
        else          v = ramp(PER - 1 - p, HALF - 1);
      end
      2'b10:   v = ramp(p, PER - 1);
      default: v = MAXV;
    endcase
    return WIDTH'(v);
  endfunction

  logic [DELAY_W-1:0]        counter;
  logic [POS_W-1:0]          pos;
  logic [1:0]                mode_q;
  logic [WIDTH-1:0]          pwm_cnt;
  logic                      advance;
  logic                      pos_last;
  logic [CHANNELS*WIDTH-1:0] level_p0;

  // Live compare: lowering step_delay below the running count advances at once.
  assign advance  = en && (counter >= step_delay);
  assign pos_last = (pos == POS_W'(PERIOD - 1));

  // ---- stage 0: divider, position, cycle-aligned mode latch ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      pos     <= '0;
      mode_q  <= 2'b00;
      wrap    <= 1'b0;
    end else begin
      wrap <= advance && pos_last;
      if (advance) begin
        counter <= '0;
        if (pos_last) begin
          pos    <= '0;
          // Shape may only change at the start of a cycle.
          mode_q <= mode;
        end else begin
          pos <= pos + POS_W'(1);
        end
      end else if (en) begin
        counter <= counter + DELAY_W'(1);
      end
    end
  end

  always_comb begin
    level_p0 = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      level_p0[i*WIDTH +: WIDTH] = shape_level(chan_phase(pos, i), mode_q);
    end
  end

  // ---- stage 1: registered levels (refreshed every cycle, even with en low) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_out <= '0;
    end else begin
      level_out <= level_p0;
    end
  end

  // ---- stage 2: free-running PWM compare against the registered level ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_out <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + WIDTH'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= (pwm_cnt < level_out[i*WIDTH +: WIDTH]);
      end
    end
  end

endmodule

// File: tb/tb_fade_gen_multi.sv
// Testbench for fade_gen_multi: a reference model advanced on every rising
// edge pushes the expected outputs into a queue; a monitor on the falling edge
// pops and compares. Directed phases cover the documented scenarios, then a
// randomized phase exercises en, step_delay and mode.
module tb_fade_gen_multi;

  localparam int WIDTH       = 10;
  localparam int CHANNELS    = 3;
  localparam int PERIOD      = 360;
  localparam int OFFSET_STEP = 120;
  localparam int DELAY_W     = 22;
  localparam int MAXV        = 1023;
  localparam int NVEC        = 10;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      en;
  logic [DELAY_W-1:0]        step_delay;
  logic [1:0]                mode;
  logic [CHANNELS*WIDTH-1:0] level_out;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      wrap;

  always #5 clk = ~clk;

  fade_gen_multi #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .PERIOD(PERIOD),
    .OFFSET_STEP(OFFSET_STEP), .DELAY_W(DELAY_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .step_delay(step_delay), .mode(mode),
    .level_out(level_out), .pwm_out(pwm_out), .wrap(wrap)
  );

  typedef struct packed {
    logic [CHANNELS*WIDTH-1:0] lvl;
    logic [CHANNELS-1:0]       pwm;
    logic                      wrp;
    logic [1:0]                lmode;
    logic [8:0]                ph0;
    logic                      live;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state, expressed as plain integers.
  int m_cnt, m_pos, m_modeq, m_pwmcnt;
  int m_lvl[CHANNELS];

  // Documented shape points for channel 0: mode, phase, level.
  int  vm[NVEC] = '{0, 0, 0, 0, 2, 2, 1, 1, 1, 1};
  int  vp[NVEC] = '{30, 59, 180, 239, 180, 359, 90, 179, 180, 359};
  int  vv[NVEC] = '{520, 1023, 1023, 0, 512, 1023, 514, 1023, 1023, 0};
  bit  vseen[NVEC];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic int ref_level(input int p, input int m);
    int seg, half;
    seg  = PERIOD / 6;
    half = PERIOD / 2;
    case (m)
      0: begin
        if (p < seg)          return (p * MAXV) / (seg - 1);
        else if (p < 3 * seg) return MAXV;
        else if (p < 4 * seg) return ((4 * seg - 1 - p) * MAXV) / (seg - 1);
        else                  return 0;
      end
      1:       return (p < half) ? (p * MAXV) / (half - 1) : ((PERIOD - 1 - p) * MAXV) / (half - 1);
      2:       return (p * MAXV) / (PERIOD - 1);
      default: return MAXV;
    endcase
  endfunction

  function automatic int ref_phase(input int pos, input int ch);
    return (pos + ch * OFFSET_STEP) % PERIOD;
  endfunction

  // Model: on each rising edge compute what the outputs become after it.
  initial begin
    forever begin
      exp_t e;
      int   nl[CHANNELS];
      bit   adv;
      @(posedge clk);
      e = '0;
      if (!rst_n) begin
        m_cnt = 0; m_pos = 0; m_modeq = 0; m_pwmcnt = 0;
        for (int c = 0; c < CHANNELS; c++) m_lvl[c] = 0;
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          nl[c]    = ref_level(ref_phase(m_pos, c), m_modeq);
          e.pwm[c] = (m_pwmcnt < m_lvl[c]);
          e.lvl[c*WIDTH +: WIDTH] = WIDTH'(nl[c]);
        end
        e.lmode = 2'(m_modeq);
        e.ph0   = 9'(m_pos);
        e.live  = 1'b1;
        adv     = en && (m_cnt >= int'(step_delay));
        e.wrp   = adv && (m_pos == PERIOD - 1);
        if (adv) begin
          m_cnt = 0;
          m_pos = (m_pos + 1) % PERIOD;
          if (m_pos == 0) m_modeq = int'(mode);
        end else if (en) begin
          m_cnt = m_cnt + 1;
        end
        m_pwmcnt = (m_pwmcnt + 1) % (1 << WIDTH);
        for (int c = 0; c < CHANNELS; c++) m_lvl[c] = nl[c];
      end
      q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the oldest pending expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int c = 0; c < CHANNELS; c++) begin
          check($sformatf("level ch%0d", c), int'(level_out[c*WIDTH +: WIDTH]), int'(e.lvl[c*WIDTH +: WIDTH]));
          check($sformatf("pwm ch%0d", c), int'(pwm_out[c]), int'(e.pwm[c]));
        end
        check("wrap", int'(wrap), int'(e.wrp));
        if (e.live) begin
          for (int k = 0; k < NVEC; k++) begin
            if (int'(e.lmode) == vm[k] && int'(e.ph0) == vp[k]) begin
              check($sformatf("shape mode%0d p%0d", vm[k], vp[k]), int'(level_out[WIDTH-1:0]), vv[k]);
              vseen[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Advance with step_delay=0 until the model position reaches target, then freeze.
  task automatic run_to_pos(input int target);
    int guard;
    guard      = 0;
    step_delay = '0;
    en         = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (m_pos != target && guard < 3 * PERIOD);
    en = 1'b0;
    if (m_pos != target) check("run_to_pos timeout", m_pos, target);
  endtask

  task automatic pwm_count(input string name, input int req);
    int hi;
    hi = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < (1 << WIDTH); i++) begin
      if (pwm_out[0]) hi++;
      @(negedge clk);
    end
    check(name, hi, req);
  endtask

  initial begin
    int nwrap, guard, nseen;
    rst_n = 1'b0; en = 1'b0; step_delay = '0; mode = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Default run: trapezoid, one advance per cycle.
    en = 1'b1;
    repeat (20) @(negedge clk);
    nwrap = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (wrap) nwrap++;
      @(negedge clk);
    end
    check("wraps per 360 cycles", nwrap, 1);
    repeat (20) @(negedge clk);

    // step_delay=4, then drop to 1 while the counter is at 3.
    step_delay = 22'd4;
    guard = 0;
    while (m_cnt != 3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (m_cnt != 3) check("counter reach 3", m_cnt, 3);
    step_delay = 22'd1;
    repeat (10) @(negedge clk);
    step_delay = 22'd4;
    repeat (12) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (12) @(negedge clk);

    // Mode change mid-cycle waits for the wrap, then sawtooth.
    run_to_pos(100);
    mode = 2'b10;
    run_to_pos(0);
    run_to_pos(359);
    run_to_pos(180);
    pwm_count("pwm high count level 512", 512);

    mode = 2'b00;
    run_to_pos(0);
    pwm_count("pwm high count level 0", 0);
    run_to_pos(60);
    pwm_count("pwm high count level 1023", 1023);

    // Triangle cycle.
    mode = 2'b01;
    run_to_pos(0);
    run_to_pos(359);
    repeat (3) @(negedge clk);

    // Async reset mid-step: counter=2, pos=200, mode_q=10.
    mode = 2'b10;
    run_to_pos(0);
    run_to_pos(200);
    step_delay = 22'd4;
    en = 1'b1;
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (m_cnt != 2) check("counter reach 2", m_cnt, 2);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("reset level_out", int'(level_out), 0);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset wrap", int'(wrap), 0);
    en = 1'b0;
    mode = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset ch0", int'(level_out[9:0]), 0);
    check("post-reset ch1", int'(level_out[19:10]), MAXV);
    check("post-reset ch2", int'(level_out[29:20]), 0);

    // Randomized operation.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) step_delay = DELAY_W'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    nseen = 0;
    for (int k = 0; k < NVEC; k++) if (vseen[k]) nseen++;
    check("documented shape points reached", nseen, NVEC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
